// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cacheline backing-memory arbiter.
// Covers the arbiter state, the last-grant marker and the default line width.
package cacheline_mem_arbiter_pkg;

    localparam int unsigned CACHELINE_WIDTH = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I_BUSY,
        ARB_D_BUSY
    } mem_arb_state_t;

    typedef enum logic {
        GNT_ICACHE,
        GNT_DCACHE
    } mem_arb_gnt_t;

endpackage

// File: rtl/cacheline_mem_arbiter.sv
// Round-robin arbiter sharing one cacheline-wide memory port between icache and dcache.
// A grant is held until bmem_resp; bmem_* commands are registered.
module cacheline_mem_arbiter
    import cacheline_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = CACHELINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [LINE_WIDTH-1:0] bmem_wdata,
    input  logic [LINE_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_resp
);

    mem_arb_state_t        state_q, state_d;
    mem_arb_gnt_t          last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] bmem_addr_q, bmem_addr_d;
    logic                  bmem_read_q, bmem_read_d;
    logic                  bmem_write_q, bmem_write_d;
    logic [LINE_WIDTH-1:0] bmem_wdata_q, bmem_wdata_d;
    logic                  dreq;

    assign dreq = d_read | d_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bmem_addr_d  = bmem_addr_q;
        bmem_read_d  = bmem_read_q;
        bmem_write_d = bmem_write_q;
        bmem_wdata_d = bmem_wdata_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;

        case (state_q)
            ARB_IDLE: begin
                bmem_read_d  = 1'b0;
                bmem_write_d = 1'b0;
                // Icache wins a tie only when the dcache was served last.
                if (i_read && (!dreq || last_grant_q == GNT_DCACHE)) begin
                    state_d      = ARB_I_BUSY;
                    last_grant_d = GNT_ICACHE;
                    bmem_addr_d  = i_addr;
                    bmem_read_d  = 1'b1;
                end else if (dreq) begin
                    state_d      = ARB_D_BUSY;
                    last_grant_d = GNT_DCACHE;
                    bmem_addr_d  = d_addr;
                    // A simultaneous read+write issues the write-back only.
                    bmem_write_d = d_write;
                    bmem_read_d  = ~d_write;
                    bmem_wdata_d = d_wdata;
                end
            end
            ARB_I_BUSY: begin
                if (bmem_resp) begin
                    state_d      = ARB_IDLE;
                    bmem_read_d  = 1'b0;
                    bmem_write_d = 1'b0;
                    // A withdrawn requester gets no response.
                    if (i_read) begin
                        i_resp  = 1'b1;
                        i_rdata = bmem_rdata;
                    end
                end
            end
            ARB_D_BUSY: begin
                if (bmem_resp) begin
                    state_d      = ARB_IDLE;
                    bmem_read_d  = 1'b0;
                    bmem_write_d = 1'b0;
                    if (dreq) begin
                        d_resp  = 1'b1;
                        d_rdata = bmem_rdata;
                    end
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                bmem_read_d  = 1'b0;
                bmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_DCACHE;
            bmem_addr_q  <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bmem_addr_q  <= bmem_addr_d;
            bmem_read_q  <= bmem_read_d;
            bmem_write_q <= bmem_write_d;
            bmem_wdata_q <= bmem_wdata_d;
        end
    end

    assign bmem_addr  = bmem_addr_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed self-checking bench for cacheline_mem_arbiter.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cacheline_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] i_addr = '0;
    logic          i_read = 1'b0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [AW-1:0] d_addr = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [LW-1:0] bmem_wdata;
    logic [LW-1:0] bmem_rdata = '0;
    logic          bmem_resp = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    localparam logic [LW-1:0] LINE_A5 = {32{8'hA5}};
    localparam logic [LW-1:0] LINE_WB = {4{64'h0123456789ABCDEF}};

    cacheline_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_addr    (i_addr),
        .i_read    (i_read),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_addr    (d_addr),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .bmem_addr (bmem_addr),
        .bmem_read (bmem_read),
        .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata),
        .bmem_rdata(bmem_rdata),
        .bmem_resp (bmem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bmem_read !== 1'b0) $display("FAIL rst_read: got %0b want 0", bmem_read); else n_pass++;
        n_checks++; if (bmem_write !== 1'b0) $display("FAIL rst_write: got %0b want 0", bmem_write); else n_pass++;
        n_checks++; if (bmem_addr !== '0) $display("FAIL rst_addr: got %h want 0", bmem_addr); else n_pass++;
        n_checks++; if (bmem_wdata !== '0) $display("FAIL rst_wdata: got %h want 0", bmem_wdata); else n_pass++;
        n_checks++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL rst_resp: got %b want 00", {i_resp, d_resp}); else n_pass++;
        n_checks++; if ((i_rdata | d_rdata) !== '0) $display("FAIL rst_rdata: got %h want 0", i_rdata | d_rdata); else n_pass++;
    endtask

    task automatic test_icache_read();
        i_addr = 32'h1eceb000;
        i_read = 1'b1;
        tick();
        n_checks++; if (bmem_read !== 1'b1) $display("FAIL t1_cmd: got %0b want 1", bmem_read); else n_pass++;
        n_checks++; if (bmem_addr !== 32'h1eceb000) $display("FAIL t1_addr: got %h want 1eceb000", bmem_addr); else n_pass++;
        n_checks++; if (bmem_write !== 1'b0) $display("FAIL t1_nowrite: got %0b want 0", bmem_write); else n_pass++;
        n_checks++; if (i_rdata !== '0) $display("FAIL t1_rdata_idle: got %h want 0", i_rdata); else n_pass++;
        tick();
        tick();
        n_checks++; if (bmem_read !== 1'b1) $display("FAIL t1_held: got %0b want 1", bmem_read); else n_pass++;
        bmem_rdata = LINE_A5;
        bmem_resp  = 1'b1;
        #1;
        n_checks++; if (i_resp !== 1'b1) $display("FAIL t1_iresp: got %0b want 1", i_resp); else n_pass++;
        n_checks++; if (i_rdata !== LINE_A5) $display("FAIL t1_irdata: got %h want %h", i_rdata, LINE_A5); else n_pass++;
        n_checks++; if (d_resp !== 1'b0) $display("FAIL t1_dresp: got %0b want 0", d_resp); else n_pass++;
        tick();
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        i_read     = 1'b0;
        #1;
        n_checks++; if (bmem_read !== 1'b0) $display("FAIL t1_drop: got %0b want 0", bmem_read); else n_pass++;
        n_checks++; if (i_resp !== 1'b0) $display("FAIL t1_pulse: got %0b want 0", i_resp); else n_pass++;
    endtask

    task automatic test_dcache_write();
        d_addr  = 32'h1eceb020;
        d_wdata = LINE_WB;
        d_write = 1'b1;
        tick();
        n_checks++; if (bmem_write !== 1'b1) $display("FAIL t2_cmd: got %0b want 1", bmem_write); else n_pass++;
        n_checks++; if (bmem_read !== 1'b0) $display("FAIL t2_noread: got %0b want 0", bmem_read); else n_pass++;
        n_checks++; if (bmem_wdata !== LINE_WB) $display("FAIL t2_wdata: got %h want %h", bmem_wdata, LINE_WB); else n_pass++;
        n_checks++; if (bmem_addr !== 32'h1eceb020) $display("FAIL t2_addr: got %h want 1eceb020", bmem_addr); else n_pass++;
        tick();
        bmem_resp = 1'b1;
        #1;
        n_checks++; if ({i_resp, d_resp} !== 2'b01) $display("FAIL t2_resp: got %b want 01", {i_resp, d_resp}); else n_pass++;
        tick();
        bmem_resp = 1'b0;
        d_write   = 1'b0;
        #1;
        n_checks++; if ({bmem_read, bmem_write, d_resp} !== 3'b000) $display("FAIL t2_idle: got %b want 000", {bmem_read, bmem_write, d_resp}); else n_pass++;
        tick();
        n_checks++; if ({bmem_read, bmem_write} !== 2'b00) $display("FAIL t2_stay: got %b want 00", {bmem_read, bmem_write}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int last_cyc;
        logic exp_i;
        apply_reset();
        last_cyc = 0;
        i_addr = 32'h0000_1000;
        d_addr = 32'h0000_2000;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k % 2 == 0);
            tick();
            n_checks++; if (bmem_read !== 1'b1) $display("FAIL t3_cmd%0d: got %0b want 1", k, bmem_read); else n_pass++;
            n_checks++; if (bmem_addr !== (exp_i ? 32'h0000_1000 : 32'h0000_2000)) $display("FAIL t3_order%0d: got %h want %h", k, bmem_addr, exp_i ? 32'h0000_1000 : 32'h0000_2000); else n_pass++;
            if (k > 0) begin
                n_checks++; if (cyc - last_cyc !== 3) $display("FAIL t3_rate%0d: got %0d want 3", k, cyc - last_cyc); else n_pass++;
            end
            last_cyc = cyc;
            tick();
            bmem_rdata = {8{k[31:0]}};
            bmem_resp  = 1'b1;
            #1;
            n_checks++; if ({i_resp, d_resp} !== {exp_i, ~exp_i}) $display("FAIL t3_resp%0d: got %b want %b", k, {i_resp, d_resp}, {exp_i, ~exp_i}); else n_pass++;
            tick();
            bmem_resp  = 1'b0;
            bmem_rdata = '0;
            #1;
            n_checks++; if ({i_resp, d_resp, bmem_read} !== 3'b000) $display("FAIL t3_pulse%0d: got %b want 000", k, {i_resp, d_resp, bmem_read}); else n_pass++;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
    endtask

    task automatic test_read_write_both();
        d_addr  = 32'h0000_3000;
        d_wdata = LINE_A5;
        d_read  = 1'b1;
        d_write = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if ({bmem_read, bmem_write} !== 2'b01) $display("FAIL t4_cmd%0d: got %b want 01", k, {bmem_read, bmem_write}); else n_pass++;
        end
        bmem_resp = 1'b1;
        #1;
        n_checks++; if (d_resp !== 1'b1) $display("FAIL t4_dresp: got %0b want 1", d_resp); else n_pass++;
        tick();
        bmem_resp = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        d_addr  = 32'h0000_4000;
        d_wdata = LINE_WB;
        d_write = 1'b1;
        tick();
        n_checks++; if (bmem_write !== 1'b1) $display("FAIL t5_pre: got %0b want 1", bmem_write); else n_pass++;
        rst_n     = 1'b0;
        bmem_resp = 1'b1;
        #1;
        n_checks++; if ({bmem_read, bmem_write, d_resp, i_resp} !== 4'b0000) $display("FAIL t5_abort: got %b want 0000", {bmem_read, bmem_write, d_resp, i_resp}); else n_pass++;
        n_checks++; if ((bmem_addr !== '0) || (bmem_wdata !== '0)) $display("FAIL t5_regs: got %h/%h want 0/0", bmem_addr, bmem_wdata); else n_pass++;
        tick();
        tick();
        rst_n   = 1'b1;
        d_write = 1'b0;
        #1;
        n_checks++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL t5_stray: got %b want 00", {i_resp, d_resp}); else n_pass++;
        tick();
        bmem_resp = 1'b0;
        i_addr    = 32'h0000_5000;
        i_read    = 1'b1;
        #1;
        n_checks++; if ({bmem_read, bmem_write} !== 2'b00) $display("FAIL t5_idle: got %b want 00", {bmem_read, bmem_write}); else n_pass++;
        tick();
        n_checks++; if ((bmem_read !== 1'b1) || (bmem_addr !== 32'h0000_5000)) $display("FAIL t5_next: got %0b/%h want 1/00005000", bmem_read, bmem_addr); else n_pass++;
        bmem_rdata = LINE_WB;
        bmem_resp  = 1'b1;
        #1;
        n_checks++; if ((i_resp !== 1'b1) || (i_rdata !== LINE_WB)) $display("FAIL t5_iresp: got %0b/%h want 1/%h", i_resp, i_rdata, LINE_WB); else n_pass++;
        tick();
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        i_read     = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        apply_reset();
        i_addr = 32'h0000_6000;
        d_addr = 32'h0000_7000;
        i_read = 1'b1;
        tick();
        n_checks++; if ((bmem_read !== 1'b1) || (bmem_addr !== 32'h0000_6000)) $display("FAIL t6_grant: got %0b/%h want 1/00006000", bmem_read, bmem_addr); else n_pass++;
        i_read = 1'b0;
        i_addr = 32'h0000_6666;
        d_read = 1'b1;
        tick();
        n_checks++; if ((bmem_read !== 1'b1) || (bmem_addr !== 32'h0000_6000)) $display("FAIL t6_held: got %0b/%h want 1/00006000", bmem_read, bmem_addr); else n_pass++;
        bmem_rdata = LINE_A5;
        bmem_resp  = 1'b1;
        #1;
        n_checks++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL t6_discard: got %b want 00", {i_resp, d_resp}); else n_pass++;
        n_checks++; if ((i_rdata | d_rdata) !== '0) $display("FAIL t6_rdata: got %h want 0", i_rdata | d_rdata); else n_pass++;
        tick();
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        #1;
        n_checks++; if (bmem_read !== 1'b0) $display("FAIL t6_idle: got %0b want 0", bmem_read); else n_pass++;
        tick();
        n_checks++; if ((bmem_read !== 1'b1) || (bmem_addr !== 32'h0000_7000)) $display("FAIL t6_dgrant: got %0b/%h want 1/00007000", bmem_read, bmem_addr); else n_pass++;
        bmem_resp = 1'b1;
        #1;
        n_checks++; if ({i_resp, d_resp} !== 2'b01) $display("FAIL t6_dresp: got %b want 01", {i_resp, d_resp}); else n_pass++;
        tick();
        bmem_resp = 1'b0;
        d_read    = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_back_to_back();
        test_read_write_both();
        test_reset_mid_op();
        test_withdraw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
